// File: rtl/mult_div_unit.sv
// Multicycle MIPS multiply/divide unit that owns HI/LO: shift-add multiply,
// restoring divide, one bit per cycle, plus direct mthi/mtlo writes.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t             state;
    state_t             next_state;

    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               dz_q;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   opa;
    logic [WIDTH-1:0]   opb;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               is_signed;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               zero_div;
    logic               last;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     shifted;
    logic               ge;
    logic [WIDTH-1:0]   rem_next;

    assign is_signed = ~op[0];
    assign a_mag     = (is_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag     = (is_signed && b[WIDTH-1]) ? -b : b;
    assign zero_div  = op[1] && (b == '0);
    assign last      = (cnt == CW'(WIDTH - 1));

    // Multiply: add the multiplicand into the upper half when the current
    // multiplier bit (acc LSB) is set, then shift the whole accumulator right.
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opa : '0)};

    // Divide: the remainder stays below the divisor, so the shifted partial
    // remainder fits in WIDTH+1 bits and the restored value fits in WIDTH.
    assign shifted  = {rem, quot[WIDTH-1]};
    assign ge       = (shifted >= {1'b0, opb});
    assign rem_next = ge ? WIDTH'(shifted - {1'b0, opb}) : shifted[WIDTH-1:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = zero_div ? DONE : RUN;
            RUN:     if (last)  next_state = FIX;
            FIX:     next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz_q   <= 1'b0;
            cnt    <= '0;
            opa    <= '0;
            opb    <= '0;
            acc    <= '0;
            rem    <= '0;
            quot   <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hi_we) hi_q <= wdata;
                    if (lo_we) lo_q <= wdata;
                    if (start) begin
                        is_div <= op[1];
                        neg_q  <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r  <= is_signed & a[WIDTH-1];
                        dz_q   <= zero_div;
                        cnt    <= '0;
                        opa    <= a_mag;
                        opb    <= b_mag;
                        acc    <= {{WIDTH{1'b0}}, b_mag};
                        rem    <= '0;
                        quot   <= a_mag;
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (is_div) begin
                        rem  <= rem_next;
                        quot <= {quot[WIDTH-2:0], ge};
                    end else begin
                        acc  <= {mul_sum, acc[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    if (is_div) begin
                        lo_q <= neg_q ? -quot : quot;
                        hi_q <= neg_r ? -rem : rem;
                    end else begin
                        {hi_q, lo_q} <= neg_q ? -acc : acc;
                    end
                end
                DONE: dz_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit at WIDTH=32 with
// hand-computed HI/LO results, latencies and divide-by-zero behaviour.
module tb_mult_div_unit;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int failures;
    int lat;
    int busy_cycles;
    logic dz_seen;

    mult_div_unit #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
        .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Launches one operation and follows it back to IDLE; called and returns
    // 1 time unit after a rising edge.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                                 output int lat_o, output int bc_o, output logic dz_o);
        op = o; a = av; b = bv; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; a = 32'h5A5A_5A5A; b = 32'hA5A5_A5A5; op = ~o;
        lat_o = -1; bc_o = 0; dz_o = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (busy) bc_o++;
            if (done && lat_o < 0) begin
                lat_o = i;
                dz_o  = div_zero;
            end
            if (!busy) break;
            @(posedge clock); #1;
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        #12;
        checkOutput("reset_busy", {63'd0, busy}, 64'd0);
        checkOutput("reset_done", {63'd0, done}, 64'd0);
        checkOutput("reset_dz", {63'd0, div_zero}, 64'd0);
        checkOutput("reset_hi", {32'd0, hi}, 64'd0);
        checkOutput("reset_lo", {32'd0, lo}, 64'd0);
        reset = 1'b1;
        @(posedge clock); #1;

        applyStimulus(2'b00, 32'hFFFF_FFFD, 32'd5, lat, busy_cycles, dz_seen);
        checkOutput("mult_latency", 64'(lat), 64'd33);
        checkOutput("mult_busy_cycles", 64'(busy_cycles), 64'd34);
        checkOutput("mult_hi", {32'd0, hi}, 64'hFFFF_FFFF);
        checkOutput("mult_lo", {32'd0, lo}, 64'hFFFF_FFF1);

        applyStimulus(2'b01, 32'hFFFF_FFFF, 32'd2, lat, busy_cycles, dz_seen);
        checkOutput("multu_hi", {32'd0, hi}, 64'h1);
        checkOutput("multu_lo", {32'd0, lo}, 64'hFFFF_FFFE);

        applyStimulus(2'b00, 32'hFFFF_FFFF, 32'd2, lat, busy_cycles, dz_seen);
        checkOutput("mult_neg1_hi", {32'd0, hi}, 64'hFFFF_FFFF);
        checkOutput("mult_neg1_lo", {32'd0, lo}, 64'hFFFF_FFFE);

        applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2, lat, busy_cycles, dz_seen);
        checkOutput("div_latency", 64'(lat), 64'd33);
        checkOutput("div_m7_2_lo", {32'd0, lo}, 64'hFFFF_FFFD);
        checkOutput("div_m7_2_hi", {32'd0, hi}, 64'hFFFF_FFFF);

        applyStimulus(2'b10, 32'd7, 32'hFFFF_FFFE, lat, busy_cycles, dz_seen);
        checkOutput("div_7_m2_lo", {32'd0, lo}, 64'hFFFF_FFFD);
        checkOutput("div_7_m2_hi", {32'd0, hi}, 64'h1);

        applyStimulus(2'b11, 32'd100, 32'd7, lat, busy_cycles, dz_seen);
        checkOutput("divu_100_7_lo", {32'd0, lo}, 64'd14);
        checkOutput("divu_100_7_hi", {32'd0, hi}, 64'd2);

        applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, busy_cycles, dz_seen);
        checkOutput("div_minneg_lo", {32'd0, lo}, 64'h8000_0000);
        checkOutput("div_minneg_hi", {32'd0, hi}, 64'd0);
        checkOutput("div_minneg_dz", {63'd0, dz_seen}, 64'd0);

        hi_we = 1'b1; wdata = 32'h11;
        @(posedge clock); #1;
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h22;
        @(posedge clock); #1;
        lo_we = 1'b0;
        checkOutput("mthi", {32'd0, hi}, 64'h11);
        checkOutput("mtlo", {32'd0, lo}, 64'h22);

        applyStimulus(2'b11, 32'd7, 32'd0, lat, busy_cycles, dz_seen);
        checkOutput("dz_latency", 64'(lat), 64'd0);
        checkOutput("dz_flag", {63'd0, dz_seen}, 64'd1);
        checkOutput("dz_busy_cycles", 64'(busy_cycles), 64'd1);
        checkOutput("dz_flag_cleared", {63'd0, div_zero}, 64'd0);
        checkOutput("dz_hi_kept", {32'd0, hi}, 64'h11);
        checkOutput("dz_lo_kept", {32'd0, lo}, 64'h22);

        // Launch, then poke start and hi_we mid-RUN; both must be ignored.
        op = 2'b01; a = 32'h0001_0000; b = 32'h0003_0000; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                lat = i;
                break;
            end
            start = (i == 5); hi_we = (i == 5);
            op = 2'b11; a = 32'd9; b = 32'd3; wdata = 32'hDEAD;
            @(posedge clock); #1;
        end
        start = 1'b0; hi_we = 1'b0;
        checkOutput("immune_latency", 64'(lat), 64'd33);
        checkOutput("immune_hi", {32'd0, hi}, 64'h3);
        checkOutput("immune_lo", {32'd0, lo}, 64'h0);
        @(posedge clock); #1;
        checkOutput("immune_idle", {63'd0, busy}, 64'd0);

        op = 2'b01; a = 32'd5; b = 32'd5; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #3 reset = 1'b0;
        #1;
        checkOutput("abort_busy", {63'd0, busy}, 64'd0);
        checkOutput("abort_done", {63'd0, done}, 64'd0);
        checkOutput("abort_hi", {32'd0, hi}, 64'd0);
        checkOutput("abort_lo", {32'd0, lo}, 64'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;

        applyStimulus(2'b01, 32'd3, 32'd4, lat, busy_cycles, dz_seen);
        checkOutput("post_reset_latency", 64'(lat), 64'd33);
        checkOutput("post_reset_hi", {32'd0, hi}, 64'd0);
        checkOutput("post_reset_lo", {32'd0, lo}, 64'd12);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
